// File: rtl/w_bus_pkg.sv
// rtl/w_bus_pkg.sv - shared W-bus widths, state encodings and error read value
package w_bus_pkg;

   localparam int W_ADDR_W = 32;
   localparam int W_DATA_W = 32;
   localparam int W_BE_W   = 4;

   localparam logic [W_DATA_W-1:0] W_ERR_RDATA = 32'h0;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } w_state_e;

   // Plain vector encodings so the state register stays a legacy-compatible logic vector
   localparam logic [1:0] ST_IDLE   = 2'(IDLE);
   localparam logic [1:0] ST_WAIT   = 2'(WAIT);
   localparam logic [1:0] ST_ACCESS = 2'(ACCESS);
   localparam logic [1:0] ST_RESP   = 2'(RESP);

endpackage

// File: rtl/w_bus_ram.sv
// rtl/w_bus_ram.sv - single-port synchronous RAM, per-byte write, read-first
module w_bus_ram
   import w_bus_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                en,
   input  logic                we,
   input  logic [W_BE_W-1:0]   be,
   input  logic [AW-1:0]       addr,
   input  logic [W_DATA_W-1:0] wdata,
   output logic [W_DATA_W-1:0] rdata
);

   logic [W_DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (en) begin
         rdata <= mem[addr];
         if (we) begin
            for (int i = 0; i < W_BE_W; i++) begin
               if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
      end
   end

endmodule

// File: rtl/w_bus_ram_responder.sv
// rtl/w_bus_ram_responder.sv - W-bus responder: window decode, wait states, RAM access, ACK/ERR
module w_bus_ram_responder
   import w_bus_pkg::*;
#(
   parameter logic [31:0] ADDR_BASE   = 32'h0000_1000,
   parameter int          DEPTH_WORDS = 256,
   parameter int          WAIT_STATES = 0
) (
   input  logic                W_CLK,
   input  logic                W_RST_N,
   input  logic                W_REQ,
   input  logic                W_WRITE,
   input  logic [W_ADDR_W-1:0] W_ADDR,
   input  logic [W_DATA_W-1:0] W_WDATA,
   input  logic [W_BE_W-1:0]   W_BE,
   output logic [W_DATA_W-1:0] W_RDATA,
   output logic                W_ACK,
   output logic                W_ERR
);

   localparam int          IDX_W  = $clog2(DEPTH_WORDS);
   localparam logic [32:0] WIN_LO = {1'b0, ADDR_BASE};
   localparam logic [32:0] WIN_HI = WIN_LO + 33'(4 * DEPTH_WORDS);
   localparam logic [3:0]  WS     = 4'(WAIT_STATES);

   logic [W_ADDR_W-1:0] addr_word;
   logic [W_ADDR_W-1:0] offset;
   logic                in_range;

   // 33-bit compare keeps a window ending at the top of the address space from wrapping
   assign addr_word = {W_ADDR[W_ADDR_W-1:2], 2'b00};
   assign offset    = addr_word - ADDR_BASE;
   assign in_range  = ({1'b0, addr_word} >= WIN_LO) && ({1'b0, addr_word} < WIN_HI);

   logic [1:0]          state;
   logic [3:0]          wait_cnt;
   logic                wr_q;
   logic                in_range_q;
   logic [IDX_W-1:0]    idx_q;
   logic [W_DATA_W-1:0] wdata_q;
   logic [W_BE_W-1:0]   be_q;
   logic [W_DATA_W-1:0] ram_rdata;

   always_ff @(posedge W_CLK or negedge W_RST_N) begin
      if (!W_RST_N) begin
         state      <= ST_IDLE;
         wait_cnt   <= 4'd0;
         wr_q       <= 1'b0;
         in_range_q <= 1'b0;
         idx_q      <= '0;
         wdata_q    <= '0;
         be_q       <= '0;
         W_ACK      <= 1'b0;
         W_ERR      <= 1'b0;
         W_RDATA    <= '0;
      end else begin
         W_ACK <= 1'b0;
         W_ERR <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (W_REQ) begin
                  wr_q       <= W_WRITE;
                  in_range_q <= in_range;
                  idx_q      <= offset[IDX_W+1:2];
                  wdata_q    <= W_WDATA;
                  be_q       <= W_BE;
                  if (WAIT_STATES > 0) begin
                     wait_cnt <= WS;
                     state    <= ST_WAIT;
                  end else begin
                     state    <= ST_ACCESS;
                  end
               end
            end
            ST_WAIT: begin
               wait_cnt <= wait_cnt - 4'd1;
               if (wait_cnt <= 4'd1) state <= ST_ACCESS;
            end
            ST_ACCESS: state <= ST_RESP;
            ST_RESP: begin
               W_ACK <= 1'b1;
               W_ERR <= !in_range_q;
               if (!wr_q) W_RDATA <= in_range_q ? ram_rdata : W_ERR_RDATA;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   w_bus_ram #(
      .DEPTH (DEPTH_WORDS),
      .AW    (IDX_W)
   ) u_ram (
      .clk   (W_CLK),
      .en    ((state == ST_ACCESS) && in_range_q),
      .we    (wr_q),
      .be    (be_q),
      .addr  (idx_q),
      .wdata (wdata_q),
      .rdata (ram_rdata)
   );

endmodule

// File: tb/tb_w_bus_ram_responder.sv
// tb/tb_w_bus_ram_responder.sv - directed self-checking bench for w_bus_ram_responder
module tb_w_bus_ram_responder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req   [3];
   logic        wr    [3];
   logic [31:0] addr  [3];
   logic [31:0] wdata [3];
   logic [3:0]  be    [3];
   logic [31:0] rdata [3];
   logic        ack   [3];
   logic        err   [3];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   // index 0: no wait states, 1: three wait states, 2: two wait states
   w_bus_ram_responder #(.WAIT_STATES(0)) u0 (
      .W_CLK(clk), .W_RST_N(rst_n), .W_REQ(req[0]), .W_WRITE(wr[0]), .W_ADDR(addr[0]),
      .W_WDATA(wdata[0]), .W_BE(be[0]), .W_RDATA(rdata[0]), .W_ACK(ack[0]), .W_ERR(err[0]));
   w_bus_ram_responder #(.WAIT_STATES(3)) u3 (
      .W_CLK(clk), .W_RST_N(rst_n), .W_REQ(req[1]), .W_WRITE(wr[1]), .W_ADDR(addr[1]),
      .W_WDATA(wdata[1]), .W_BE(be[1]), .W_RDATA(rdata[1]), .W_ACK(ack[1]), .W_ERR(err[1]));
   w_bus_ram_responder #(.WAIT_STATES(2)) u2 (
      .W_CLK(clk), .W_RST_N(rst_n), .W_REQ(req[2]), .W_WRITE(wr[2]), .W_ADDR(addr[2]),
      .W_WDATA(wdata[2]), .W_BE(be[2]), .W_RDATA(rdata[2]), .W_ACK(ack[2]), .W_ERR(err[2]));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic txn(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] b, output logic [31:0] rd, output logic er, output int lat);
      logic done;
      @(negedge clk);
      req[d] = 1'b1; wr[d] = w; addr[d] = a; wdata[d] = wd; be[d] = b;
      @(posedge clk);
      lat  = 0;
      done = 1'b0;
      while (!done && lat < 40) begin
         @(posedge clk); #1;
         lat++;
         if (ack[d]) done = 1'b1;
      end
      req[d] = 1'b0;
      rd = rdata[d];
      er = err[d];
      if (!done) check("ack_timeout", 32'(done), 32'd1);
   endtask

   task automatic pulse_gone(input int d, input string tag);
      @(posedge clk); #1;
      check(tag, 32'(ack[d]), 32'd0);
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lat;
      int          edges, nack, last, seen;
      logic [31:0] exp_b2b [3];
      logic [31:0] addr_b2b [3];

      rst_n = 1'b0;
      for (int d = 0; d < 3; d++) begin
         req[d] = 1'b0; wr[d] = 1'b0; addr[d] = '0; wdata[d] = '0; be[d] = '0;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         check("rst_ack", 32'(ack[d]), 32'd0);
         check("rst_err", 32'(err[d]), 32'd0);
         check("rst_rdata", rdata[d], 32'h0);
      end
      @(negedge clk);
      rst_n = 1'b1;

      // zero wait states: basic write/read
      txn(0, 1'b1, 32'h1004, 32'hCAFE_BABE, 4'hF, rd, er, lat);
      check("ws0_wr_lat", 32'(lat), 32'd2);
      check("ws0_wr_err", 32'(er), 32'd0);
      txn(0, 1'b0, 32'h1004, 32'h0, 4'h0, rd, er, lat);
      check("ws0_rd_lat", 32'(lat), 32'd2);
      check("ws0_rd_data", rd, 32'hCAFE_BABE);
      check("ws0_rd_err", 32'(er), 32'd0);
      pulse_gone(0, "ws0_ack_width");

      // byte enables and ignored low address bits
      txn(0, 1'b1, 32'h1008, 32'h1122_3344, 4'hF, rd, er, lat);
      txn(0, 1'b1, 32'h100A, 32'hAABB_CCDD, 4'b0101, rd, er, lat);
      txn(0, 1'b0, 32'h1008, 32'h0, 4'h0, rd, er, lat);
      check("be_merge", rd, 32'h11BB_33DD);
      txn(0, 1'b1, 32'h1008, 32'hFFFF_FFFF, 4'h0, rd, er, lat);
      check("be_zero_err", 32'(er), 32'd0);
      check("be_zero_lat", 32'(lat), 32'd2);
      txn(0, 1'b0, 32'h1008, 32'h0, 4'h0, rd, er, lat);
      check("be_zero_keep", rd, 32'h11BB_33DD);

      // window boundaries; 0x0FFC aliases index 0xFF if the range check were skipped
      txn(0, 1'b1, 32'h13FC, 32'hDEAD_BEEF, 4'hF, rd, er, lat);
      check("top_word_err", 32'(er), 32'd0);
      txn(0, 1'b0, 32'h1400, 32'h0, 4'h0, rd, er, lat);
      check("oor_hi_err", 32'(er), 32'd1);
      check("oor_hi_rdata", rd, 32'h0);
      txn(0, 1'b1, 32'h0FFC, 32'h1234_5678, 4'hF, rd, er, lat);
      check("oor_lo_err", 32'(er), 32'd1);
      txn(0, 1'b0, 32'h13FC, 32'h0, 4'h0, rd, er, lat);
      check("top_word_data", rd, 32'hDEAD_BEEF);
      check("top_word_rd_err", 32'(er), 32'd0);
      pulse_gone(0, "err_clear");
      check("err_clear_err", 32'(err[0]), 32'd0);
      txn(0, 1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0, rd, er, lat);
      check("oor_wrap_err", 32'(er), 32'd1);
      check("oor_wrap_rdata", rd, 32'h0);

      // back-to-back reads with W_REQ held high
      txn(0, 1'b1, 32'h1000, 32'h0102_0304, 4'hF, rd, er, lat);
      addr_b2b = '{32'h1000, 32'h1004, 32'h1008};
      exp_b2b  = '{32'h0102_0304, 32'hCAFE_BABE, 32'h11BB_33DD};
      @(negedge clk);
      req[0] = 1'b1; wr[0] = 1'b0; addr[0] = addr_b2b[0];
      edges = 0; nack = 0; last = 0;
      while (edges < 20) begin
         @(posedge clk); #1;
         edges++;
         if (ack[0]) begin
            nack++;
            if (nack <= 3) check("b2b_data", rdata[0], exp_b2b[nack-1]);
            if (nack > 1) check("b2b_spacing", 32'(edges - last), 32'd3);
            last = edges;
            if (nack < 3) addr[0] = addr_b2b[nack];
            else req[0] = 1'b0;
         end
      end
      check("b2b_ack_count", 32'(nack), 32'd3);

      // three wait states
      txn(1, 1'b1, 32'h1000, 32'h0A0B_0C0D, 4'hF, rd, er, lat);
      check("ws3_wr_lat", 32'(lat), 32'd5);
      txn(1, 1'b0, 32'h1000, 32'h0, 4'h0, rd, er, lat);
      check("ws3_rd_lat", 32'(lat), 32'd5);
      check("ws3_rd_data", rd, 32'h0A0B_0C0D);
      pulse_gone(1, "ws3_ack_width");

      // reset during WAIT drops the pending write
      txn(2, 1'b1, 32'h1010, 32'h0000_0005, 4'hF, rd, er, lat);
      check("ws2_wr_lat", 32'(lat), 32'd4);
      txn(2, 1'b0, 32'h1010, 32'h0, 4'h0, rd, er, lat);
      check("ws2_rd_data", rd, 32'h0000_0005);
      @(negedge clk);
      req[2] = 1'b1; wr[2] = 1'b1; addr[2] = 32'h1010; wdata[2] = 32'h0000_0009; be[2] = 4'hF;
      @(posedge clk);
      @(negedge clk);
      rst_n  = 1'b0;
      req[2] = 1'b0;
      #1;
      check("mid_rst_ack", 32'(ack[2]), 32'd0);
      check("mid_rst_err", 32'(err[2]), 32'd0);
      check("mid_rst_rdata", rdata[2], 32'h0);
      check("mid_rst_state", 32'(u2.state), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (ack[2]) seen++;
      end
      check("mid_rst_no_ack", 32'(seen), 32'd0);
      txn(2, 1'b0, 32'h1010, 32'h0, 4'h0, rd, er, lat);
      check("mid_rst_data_kept", rd, 32'h0000_0005);
      check("mid_rst_rd_lat", 32'(lat), 32'd4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
